// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave keypad front end and countdown digits.
package microwave_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t KEY_CLEAR = 4'd10;
    localparam bcd_t KEY_START = 4'd11;
    // Largest legal tens-of-seconds digit; the mod-6 timer digit wraps here too.
    localparam bcd_t SEC_T_MAX = 4'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_LOAD,
        ST_START,
        ST_RUN
    } entry_state_t;

    function automatic logic is_digit(input bcd_t code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Level debouncer: the filtered level follows the raw input only after DEB_CYCLES
// consecutive differing samples; rise pulses for one cycle on a filtered 0->1 change.
module key_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic Cn,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge Cn) begin
        if (!Cn) begin
            cnt_reg <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (raw == level) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_MAX) begin
                cnt_reg <= '0;
                level   <= raw;
                rise    <= raw;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

endmodule

// File: rtl/time_entry.sv
// Keypad time entry: shifts BCD digits into an MM:SS buffer, validates on START and
// sequences the load/start handshake of the countdown chain until it reports zero.
module time_entry #(
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       Cn,
    input  logic       key_valid,
    input  logic [3:0] key,
    input  logic       running,
    output logic [3:0] min_t,
    output logic [3:0] min_u,
    output logic [3:0] sec_t,
    output logic [3:0] sec_u,
    output logic       load,
    output logic       start,
    output logic       abort,
    output logic       busy,
    output logic       err
);

    import microwave_pkg::*;

    entry_state_t state_reg;
    logic [2:0]   cnt_reg;
    logic         run_q1_reg;
    logic         run_q2_reg;
    logic         key_level;
    logic         key_rise;
    logic         key_press;
    logic         run_fall;
    logic         in_busy;
    logic         abort_now;
    logic         buf_zero;

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .Cn   (Cn),
        .raw  (key_valid),
        .level(key_level),
        .rise (key_rise)
    );

    assign key_press = key_rise & key_level;
    assign run_fall  = run_q2_reg & ~run_q1_reg;
    assign in_busy   = (state_reg == ST_LOAD) || (state_reg == ST_START) || (state_reg == ST_RUN);
    assign abort_now = in_busy && key_press && (key == KEY_CLEAR);
    assign buf_zero  = ({min_t, min_u, sec_t, sec_u} == 16'h0000);

    always_ff @(posedge clk or negedge Cn) begin
        if (!Cn) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= 3'd0;
            run_q1_reg <= 1'b0;
            run_q2_reg <= 1'b0;
            {min_t, min_u, sec_t, sec_u} <= 16'h0000;
            load  <= 1'b0;
            start <= 1'b0;
            abort <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            load  <= 1'b0;
            start <= 1'b0;
            abort <= 1'b0;
            err   <= 1'b0;
            run_q1_reg <= running;
            run_q2_reg <= run_q1_reg;

            if (abort_now) begin
                {min_t, min_u, sec_t, sec_u} <= 16'h0000;
                cnt_reg   <= 3'd0;
                abort     <= 1'b1;
                busy      <= 1'b0;
                state_reg <= ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (key_press) begin
                            if (is_digit(key)) begin
                                {min_t, min_u, sec_t, sec_u} <= {min_u, sec_t, sec_u, key};
                                cnt_reg   <= 3'd1;
                                state_reg <= ST_ENTRY;
                            end else if (key != KEY_CLEAR) begin
                                err <= 1'b1;
                            end
                        end
                    end
                    ST_ENTRY: begin
                        if (key_press) begin
                            if (key == KEY_CLEAR) begin
                                {min_t, min_u, sec_t, sec_u} <= 16'h0000;
                                cnt_reg   <= 3'd0;
                                state_reg <= ST_IDLE;
                            end else if (key == KEY_START) begin
                                if (sec_t > SEC_T_MAX || buf_zero) begin
                                    err <= 1'b1;
                                end else begin
                                    load      <= 1'b1;
                                    busy      <= 1'b1;
                                    state_reg <= ST_LOAD;
                                end
                            end else if (is_digit(key) && cnt_reg != 3'd4) begin
                                {min_t, min_u, sec_t, sec_u} <= {min_u, sec_t, sec_u, key};
                                cnt_reg <= cnt_reg + 3'd1;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    ST_LOAD: begin
                        start     <= 1'b1;
                        state_reg <= ST_START;
                        err       <= key_press;
                    end
                    ST_START: begin
                        state_reg <= ST_RUN;
                        err       <= key_press;
                    end
                    ST_RUN: begin
                        // Chain reached zero: return silently, the timer clears itself.
                        if (run_fall) begin
                            {min_t, min_u, sec_t, sec_u} <= 16'h0000;
                            cnt_reg   <= 3'd0;
                            busy      <= 1'b0;
                            state_reg <= ST_IDLE;
                        end
                        err <= key_press;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/time_entry.md
# time_entry

Keypad-side front end for the microwave countdown chain. Accepts BCD digit presses, shifts them right-to-left into a four-digit MM:SS buffer, and validates the value on START. It then drives the parallel-load and enable handshake of the cascaded mod-10/mod-6 countdown digits, and tracks the run until the chain reports zero. It is the writer side of the timer's load interface: the timer digits consume `min_t/min_u/sec_t/sec_u` and `load`.

## Interface
- `DEB_CYCLES`, default 4: consecutive identical `key_valid` samples required before a press or release is recognised (≥1).
- `clk`  in  1  system clock, rising edge.
- `Cn`  in  1  asynchronous active-low reset.
- `key_valid`  in  1  level from the keypad encoder, high while a key is held.
- `key`  in  4  key code, stable while `key_valid`=1: 0–9 digit, 10 CLEAR, 11 START, 12–15 reserved.
- `running`  in  1  high while the countdown chain is counting (its Cin enable is active and zero is not reached).
- `min_t`, `min_u`, `sec_t`, `sec_u`  out  4 each  BCD buffer, parallel-load value for the timer digits.
- `load`  out  1  one-cycle pulse: timer digits capture the buffer.
- `start`  out  1  one-cycle pulse: timer chain enable asserted.
- `abort`  out  1  one-cycle pulse: stop and clear the timer chain.
- `busy`  out  1  high in LOAD, START, RUN.
- `err`  out  1  one-cycle pulse on any rejected key.

## Operation
- Debounce: a counter requires `DEB_CYCLES` equal samples of `key_valid` before the filtered level changes. A key is accepted once, on the filtered rising edge, using `key` sampled on that cycle. Auto-repeat is not supported.
- States: IDLE, ENTRY, LOAD, START, RUN. Digit count `cnt` is 0..4.
- IDLE (buffer 0000, cnt=0):
  - Digit → shift in, cnt=1, go to ENTRY.
  - START → `err` (empty entry).
  - CLEAR → no-op.
- ENTRY:
  - Digit with cnt<4 → shift: `min_t`←`min_u`, `min_u`←`sec_t`, `sec_t`←`sec_u`, `sec_u`←key, cnt+1.
  - Digit with cnt=4 → `err`, buffer unchanged.
  - CLEAR → buffer 0000, cnt=0, go to IDLE.
  - START with `sec_t`>5 or buffer 0000 → `err`, stay in ENTRY.
  - START otherwise → go to LOAD.
- LOAD: `load`=1 for one cycle, then go to START.
- START: `start`=1 for one cycle, then go to RUN.
- RUN:
  - Digit and START keys → `err`, ignored.
  - CLEAR → `abort` pulse, buffer 0000, cnt=0, go to IDLE.
  - `running` falling edge (registered) → buffer 0000, cnt=0, go to IDLE, no pulse.
- Reserved codes 12–15 → `err` in every state, with no other effect.
- Priority within a cycle: reset > CLEAR/abort > `running` fall > START > digit. Only one key can be accepted per cycle.
- Buffer is held unchanged through LOAD/START/RUN. The timer owns the live count.

## Timing
- Reset (async assert, sync-released by the upstream reset synchroniser): state IDLE, all buffer digits 0, cnt 0, filtered key 0, `load`/`start`/`abort`/`err`/`busy` 0.
- Key latency: `key_valid` rise at cycle t → filtered edge at t+`DEB_CYCLES` → buffer/state update visible after the next rising edge.
- START accepted at cycle k:
  - `load` high during k+1.
  - `start` high during k+2.
  - `busy` high from k+1.
- `running` is expected high by k+3. Its falling edge is detected one cycle after it occurs, and `busy` drops the cycle after that.
- Reset mid-RUN: outputs clear immediately. `abort` is not pulsed; the timer shares `Cn`.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package `microwave_pkg`:
  - key code constants `KEY_CLEAR`=10, `KEY_START`=11.
  - state enum `entry_state_t`.
  - BCD digit type (4 bits).
  - `SEC_T_MAX`=5 (also used by the mod-6 timer digit).
- Sub-module `key_debounce` (filtered level plus rising-edge pulse, `DEB_CYCLES` parameter), reusable for the door switch.
- FSM and shift buffer live in `time_entry`.

## Test plan
- Keys 1,3,0 then START (`DEB_CYCLES`=4) → buffer 0130; `load` pulse one cycle after START is accepted, `start` pulse the cycle after, `busy`=1.
- Keys 1,2,3,4,5 → buffer 1234, `err` pulse on the 5th key, cnt stays 4.
- Keys 9,0 then START → buffer 0090, `sec_t`=9 → `err`, no `load`, state ENTRY. CLEAR then returns to IDLE with 0000.
- START in IDLE → `err` only. Code 13 in ENTRY → `err`, buffer unchanged.
- RUN with `running`=1, press CLEAR → single `abort` pulse, buffer 0000, `busy` drops. Repeat the run and drop `running` instead → IDLE, no `abort`.
- `key_valid` glitch high for 3 cycles (`DEB_CYCLES`=4) → no acceptance. Assert `Cn`=0 mid-LOAD → all outputs 0 asynchronously, no `start` after release.
